// File: rtl/riscv_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32I control path.
// State encoding is visible on state_o, so keep the numbering stable.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_I   = 4'd2,
    EXEC_R   = 4'd3,
    WB_ALU   = 4'd4,
    WB_IMM   = 4'd5,
    MEM_ADDR = 4'd6,
    MEM_RD   = 4'd7,
    MEM_WR   = 4'd8,
    WB_MEM   = 4'd9,
    BRANCH   = 4'd10,
    JAL      = 4'd11,
    HALT     = 4'd12
  } state_t;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic {
    PC_PLUS4  = 1'b0,
    PC_TARGET = 1'b1
  } pc_src_t;

  typedef enum logic [1:0] {
    WBSEL_ALU = 2'd0,
    WBSEL_MEM = 2'd1,
    WBSEL_PC  = 2'd2,
    WBSEL_IMM = 2'd3
  } wb_sel_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2
  } alu_op_t;

  // Unsupported opcodes route to HALT; the caller flags them as illegal.
  function automatic state_t decode_next(input logic [6:0] opc);
    state_t nxt;
    case (opc)
      OPC_OPIMM:            nxt = EXEC_I;
      OPC_OP:               nxt = EXEC_R;
      OPC_LUI:              nxt = WB_IMM;
      OPC_LOAD, OPC_STORE:  nxt = MEM_ADDR;
      OPC_BRANCH:           nxt = BRANCH;
      OPC_JAL:              nxt = JAL;
      default:              nxt = HALT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory wait state.
// expired fires on the MEM_TIMEOUT-th waiting cycle unless ready arrives then.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  input  logic ready,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(MEM_TIMEOUT - 1);

  logic [15:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && !ready && count != 16'hFFFF) begin
      count <= count + 16'd1;
    end
  end

  assign expired = count_en && !ready && (count >= LAST);

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle main control FSM for the RV32I core: sequences each
// instruction through fetch/decode/execute/memory/writeback states.
module mc_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             br_cond,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired,
  output logic             illegal,
  output logic             err
);

  state_t state;
  state_t next_state;
  logic   in_wait;
  logic   wait_ready;
  logic   expired;
  logic   timer_clear;
  logic   retire_now;

  assign in_wait    = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  assign wait_ready = (state == FETCH) ? imem_ready : dmem_ready;
  assign timer_clear = (next_state != state);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .count_en(in_wait),
    .ready   (wait_ready),
    .expired (expired)
  );

  // Ready always beats the timeout, since expired is qualified by !ready.
  always_comb begin
    next_state = state;
    case (state)
      FETCH:    if (imem_ready) next_state = DECODE;
                else if (expired) next_state = HALT;
      DECODE:   next_state = decode_next(opcode);
      EXEC_I,
      EXEC_R:   next_state = WB_ALU;
      MEM_ADDR: next_state = (opcode == OPC_STORE) ? MEM_WR : MEM_RD;
      MEM_RD:   if (dmem_ready) next_state = WB_MEM;
                else if (expired) next_state = HALT;
      MEM_WR:   if (dmem_ready) next_state = FETCH;
                else if (expired) next_state = HALT;
      WB_ALU,
      WB_IMM,
      WB_MEM,
      BRANCH,
      JAL:      next_state = FETCH;
      HALT:     next_state = HALT;
      default:  next_state = HALT;
    endcase
  end

  always_comb begin
    retire_now = 1'b0;
    case (state)
      WB_ALU, WB_IMM, WB_MEM, BRANCH, JAL: retire_now = 1'b1;
      MEM_WR:                              retire_now = dmem_ready;
      default:                             retire_now = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      retired <= '0;
      illegal <= 1'b0;
      err     <= 1'b0;
    end else begin
      state <= next_state;
      if (retire_now) begin
        retired <= retired + CNT_W'(1);
      end
      if (state == DECODE && next_state == HALT) begin
        illegal <= 1'b1;
      end
      if (in_wait && expired) begin
        err <= 1'b1;
      end
    end
  end

  // Strobes are decoded from state; the few ready/br_cond terms are Mealy.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_PLUS4;
    reg_write = 1'b0;
    wb_sel    = WBSEL_ALU;
    alu_src_b = 1'b0;
    alu_op    = ALU_ADD;
    if (!reset) begin
      case (state)
        FETCH: begin
          imem_req = 1'b1;
          ir_write = imem_ready;
          pc_write = imem_ready;
        end
        EXEC_I: begin
          alu_src_b = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        EXEC_R: begin
          alu_op = ALU_FUNCT;
        end
        WB_ALU: begin
          reg_write = 1'b1;
          wb_sel    = WBSEL_ALU;
        end
        WB_IMM: begin
          reg_write = 1'b1;
          wb_sel    = WBSEL_IMM;
        end
        MEM_ADDR: begin
          alu_src_b = 1'b1;
          alu_op    = ALU_ADD;
        end
        MEM_RD: begin
          dmem_req = 1'b1;
        end
        MEM_WR: begin
          dmem_req = 1'b1;
          dmem_we  = 1'b1;
        end
        WB_MEM: begin
          reg_write = 1'b1;
          wb_sel    = WBSEL_MEM;
        end
        BRANCH: begin
          alu_op   = ALU_SUB;
          pc_src   = PC_TARGET;
          pc_write = br_cond;
        end
        JAL: begin
          reg_write = 1'b1;
          wb_sel    = WBSEL_PC;
          pc_write  = 1'b1;
          pc_src    = PC_TARGET;
        end
        default: begin
        end
      endcase
    end
  end

  assign state_o = state;

endmodule
